// File: rtl/sad_engine_if.sv
// Scheduler and frame-buffer connection for sad_engine: go/abort/done control plus
// the shared A/B read port. Valid/ready is not used; reads are strobe-plus-fixed-latency.
interface sad_engine_if #(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int AW    = 6,
    parameter int SUM_W = 16
);
    logic                   go;
    logic                   abort;
    logic                   busy;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [LANES*PIX_W-1:0] a_data;
    logic [LANES*PIX_W-1:0] b_data;
    logic [SUM_W-1:0]       sad_out;
    logic                   done;

    // Handshake: go is a level request sampled only while idle; a_data/b_data are
    // valid exactly RD_LAT cycles after rd_en; done is a one-cycle pulse that
    // coincides with the first cycle of the new sad_out.
    modport master (
        output go, abort, a_data, b_data,
        input  busy, rd_en, rd_addr, sad_out, done
    );

    modport slave (
        input  go, abort, a_data, b_data,
        output busy, rd_en, rd_addr, sad_out, done
    );
endinterface

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: streams WORDS words of LANES pixel pairs from
// the A/B memories, accumulates |A-B| and publishes the total with a done pulse.
module sad_engine #(
    parameter int PIX_W  = 8,
    parameter int N_PIX  = 256,
    parameter int LANES  = 4,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    sad_engine_if.slave  bus,
    output logic [2:0]   state_o
);
    localparam int WORDS  = N_PIX / LANES;
    localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SUM_W  = PIX_W + $clog2(N_PIX);
    localparam int TREE_W = PIX_W + $clog2(LANES);
    localparam int DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(WORDS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sad_q, sad_d;
    logic              done_q, done_d;
    logic              rd_en;
    logic              flush;
    logic [PIX_W-1:0]  lane_diff [LANES];
    logic [TREE_W-1:0] tree_sum;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W-1:0] a_k, b_k;
        assign a_k = bus.a_data[k*PIX_W +: PIX_W];
        assign b_k = bus.b_data[k*PIX_W +: PIX_W];
        // Subtract the smaller from the larger so the difference never wraps.
        assign lane_diff[k] = (a_k >= b_k) ? (a_k - b_k) : (b_k - a_k);
    end

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            tree_sum = tree_sum + TREE_W'(lane_diff[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.go) state_d = S_INIT;
            S_INIT: begin
                idx_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                rd_en   = 1'b1;
                idx_d   = idx_q + 1'b1;
                drain_d = '0;
                if (idx_q == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == LAST_DRAIN) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // DONE is deliberately not abortable so a finished sum is always published.
        if (bus.abort && (state_q == S_INIT || state_q == S_READ || state_q == S_DRAIN)) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end
    end

    always_comb begin
        vpipe_d = (vpipe_q << 1) | RD_LAT'(rd_en);
        if (flush) vpipe_d = '0;
        acc_d = acc_q;
        if (state_q == S_INIT) begin
            acc_d = '0;
        end else if (vpipe_q[RD_LAT-1]) begin
            acc_d = acc_q + SUM_W'(tree_sum);
        end
        sad_d  = sad_q;
        done_d = 1'b0;
        if (state_q == S_DONE) begin
            sad_d  = acc_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            vpipe_q <= '0;
            acc_q   <= '0;
            sad_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            vpipe_q <= vpipe_d;
            acc_q   <= acc_d;
            sad_q   <= sad_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_en ? idx_q : '0;
    assign bus.sad_out = sad_q;
    assign bus.done    = done_q;
    assign state_o     = state_q;
endmodule

// File: doc/sad_engine.md
Name: sad_engine

Overview:
- Parametrised sum-of-absolute-differences engine with the FSM controller and the datapath in one block.
- Reads two pixel blocks A and B from external synchronous memories, LANES pixel pairs per read word, and accumulates |A−B| over N_PIX pixels.
- Latches the final total into sad_out and pulses done.
- Sits between the block-match scheduler (go/abort/done) and the A/B frame-buffer read ports.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- N_PIX, 256, pixels per block; power of 2, ≥ LANES.
- LANES, 4, pixel pairs per memory word; power of 2, divides N_PIX.
- RD_LAT, 1, memory read latency in cycles, ≥1.
- Derived: WORDS = N_PIX/LANES; AW = max(1, clog2(WORDS)); SUM_W = PIX_W + clog2(N_PIX).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  cancel the current operation; honoured in INIT/READ/DRAIN.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  read strobe to both A and B memories.
- rd_addr  out  AW  word address to both memories.
- a_data  in  LANES*PIX_W  A word; lane k = bits [k*PIX_W +: PIX_W]; valid RD_LAT cycles after rd_en.
- b_data  in  LANES*PIX_W  B word; same packing and timing as a_data.
- sad_out  out  SUM_W  last completed SAD; holds its value until the next completion.
- done  out  1  one-cycle pulse, coincident with the first cycle of the new sad_out.

Behaviour:
- Reset: state=IDLE, acc=0, idx=0, read-valid pipe=0, rd_en=0, rd_addr=0, busy=0, sad_out=0, done=0. Reset mid-operation discards all in-flight reads.
- States:
  - IDLE: go=1 → INIT; else stay.
  - INIT: clear acc and idx → READ.
  - READ: rd_en=1, rd_addr=idx, idx++. After the read with idx=WORDS−1 → DRAIN.
  - DRAIN: hold for exactly RD_LAT cycles (drain counter) → DONE.
  - DONE: sad_out<=acc; done register set → IDLE.
  - Illegal encoding → IDLE.
- Datapath:
  - A valid shift register of depth RD_LAT tracks rd_en.
  - When the pipe output is 1: acc <= acc + Σ_k |a_k − b_k|.
  - Each lane difference is computed unsigned, PIX_W bits, no wrap. The adder tree is PIX_W+clog2(LANES) bits wide. acc is SUM_W bits and cannot overflow.
  - No accumulation occurs in IDLE or INIT regardless of bus contents.
- Timing (go sampled in cycle 0):
  - INIT in cycle 1.
  - READ in cycles 2..WORDS+1.
  - DRAIN in cycles WORDS+2..WORDS+RD_LAT+1.
  - DONE in cycle WORDS+RD_LAT+2.
  - done=1 and new sad_out visible in cycle WORDS+RD_LAT+3.
  - busy=1 in cycles 1..WORDS+RD_LAT+2.
- rd_en is contiguous, with no gaps, for exactly WORDS cycles per run.
- abort:
  - In INIT/READ/DRAIN, the next state is IDLE.
  - The valid pipe is flushed, rd_en drops the next cycle, no done is issued, and sad_out is unchanged.
  - abort in IDLE or DONE is ignored; DONE always completes.
- go and abort high in the same IDLE cycle: go wins (→INIT). abort takes effect from INIT.
- go held high continuously: a new run starts from the IDLE cycle after DONE, so back-to-back runs are separated by one IDLE cycle. done of run n coincides with the IDLE cycle that samples go for run n+1.
- go while busy: ignored, not queued.
- rst has priority over everything.

Test Plan:
- Defaults (N_PIX=256, LANES=4, RD_LAT=1), A=all 200, B=all 50, go pulse at cycle 0 → 64 contiguous rd_en, addr 0..63; done at cycle 68; sad_out=38400; busy high in cycles 1..67.
- A[i]=i mod 256, B[i]=255−(i mod 256) → sad_out = Σ|2i−255| = 32768. Repeat with A and B swapped → identical result.
- Worst case A=255, B=0 with N_PIX=256 → sad_out=65280, no overflow. Same run with RD_LAT=3 → done at cycle 70.
- abort at cycle 30 of a run → rd_en low from cycle 31, busy low, no done, sad_out keeps the previous value 38400. A fresh go → correct new result.
- go held high for three runs → done pulses exactly WORDS+RD_LAT+3 cycles apart; each sad_out is correct, with no carry-over of acc between runs.
- rst asserted in mid-READ with stale data still on the bus → all outputs at reset values next cycle, sad_out=0. The following go run produces an uncorrupted sum.
